stream_mux_rr: RTL and testbench

N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output. It is the next generation of the plain 2:1 data select used around the SRT-4 datapath, e.g. for quotient-digit or partial-remainder source selection and for sharing one divider core between several requesters. Channel choice is either an external select or an internal round-robin arbiter. The chosen word is held in a one-entry output register with a channel tag.

---
 rtl/stream_mux_rr_pkg.sv | 16 +
 rtl/stream_mux_rr_arb.sv | 34 +++
 rtl/stream_mux_rr.sv | 98 +++++++++
 tb/tb_stream_mux_rr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and a
// width helper reused by the other parameterised SRT blocks.
package stream_mux_rr_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Combinational rotate-priority arbiter: the first requester at or after
// ptr wins, wrapping at N_CH (not at 2^SEL_W).
module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] gnt
);

   logic [N_CH-1:0] w_mask;
   logic [N_CH-1:0] w_hi;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < N_CH; i++) w_mask[i] = (SEL_W'(i) >= ptr);
   end

   assign w_hi = req & w_mask;

   // Lowest request overall is the wrap-around fallback; a request in the
   // [ptr, N_CH-1] window overrides it.
   always_comb begin
      gnt_vld = |req;
      gnt     = '0;
      for (int i = N_CH-1; i >= 0; i--) if (req[i])  gnt = SEL_W'(i);
      for (int i = N_CH-1; i >= 0; i--) if (w_hi[i]) gnt = SEL_W'(i);
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with external-select or
// round-robin channel choice and a one-entry tagged output register.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N_CH  = 4,
   parameter  int MODE  = MUX_MODE_SEL,
   localparam int SEL_W = clog2_min1(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_ch
);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [SEL_W-1:0] r_out_ch;
   logic [SEL_W-1:0] r_rr_ptr;

   logic             w_load_en;
   logic             w_sel_vld;
   logic             w_arb_vld;
   logic [SEL_W-1:0] w_arb_gnt;
   logic             w_gnt_vld;
   logic [SEL_W-1:0] w_gnt;
   logic             w_xfer;
   logic [WIDTH-1:0] w_word;
   logic [SEL_W-1:0] w_ptr_nxt;

   rr_arbiter #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (r_rr_ptr),
      .gnt_vld (w_arb_vld),
      .gnt     (w_arb_gnt)
   );

   // An out-of-range sel matches no channel and so never grants.
   always_comb begin
      w_sel_vld = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (sel == SEL_W'(i)) w_sel_vld = in_valid[i];
   end

   assign w_gnt_vld = (MODE == MUX_MODE_RR) ? w_arb_vld : w_sel_vld;
   assign w_gnt     = (MODE == MUX_MODE_RR) ? w_arb_gnt : sel;

   assign w_load_en = !r_out_valid || out_ready;
   // Ready is withheld during reset so upstream never sees a dropped handshake.
   assign w_xfer    = !rst && w_load_en && w_gnt_vld;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_CH; i++)
         in_ready[i] = w_xfer && (w_gnt == SEL_W'(i));
   end

   always_comb begin
      w_word = '0;
      for (int i = 0; i < N_CH; i++)
         if (w_gnt == SEL_W'(i)) w_word = in_data[i*WIDTH +: WIDTH];
   end

   assign w_ptr_nxt = (w_gnt == SEL_W'(N_CH-1)) ? '0 : w_gnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_xfer) begin
            r_out_data  <= w_word;
            r_out_ch    <= w_gnt;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_xfer && (MODE == MUX_MODE_RR)) r_rr_ptr <= w_ptr_nxt;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench: four muxes (select/round-robin, 4 and 3 channels) are
// tracked by a behavioural model that queues every accepted word.
module tb_stream_mux_rr;
   import stream_mux_rr_pkg::*;

   typedef struct {
      int id;
      int ch;
      int data;
   } sb_t;

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic [1:0]  sel;
   logic [3:0]  vld  [4];
   logic        ordy [4];

   logic [3:0] rdy0, rdy1;
   logic [2:0] rdy2, rdy3;
   logic       ov0, ov1, ov2, ov3;
   logic [7:0] od0, od1, od2, od3;
   logic [1:0] och0, och1, och2, och3;

   int   n_chk  = 0;
   int   n_fail = 0;
   bit   mon_en = 0;
   bit   m_valid [4];
   int   m_ptr   [4];
   sb_t  sbq [$];

   stream_mux_rr #(.WIDTH(8), .N_CH(4), .MODE(MUX_MODE_SEL)) u_sel4 (
      .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[0]), .in_ready(rdy0),
      .sel(sel), .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]), .out_ch(och0));

   stream_mux_rr #(.WIDTH(8), .N_CH(4), .MODE(MUX_MODE_RR)) u_rr4 (
      .clk(clk), .rst(rst), .in_data(din), .in_valid(vld[1]), .in_ready(rdy1),
      .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]), .out_ch(och1));

   stream_mux_rr #(.WIDTH(8), .N_CH(3), .MODE(MUX_MODE_RR)) u_rr3 (
      .clk(clk), .rst(rst), .in_data(din[23:0]), .in_valid(vld[2][2:0]), .in_ready(rdy2),
      .sel(sel), .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]), .out_ch(och2));

   stream_mux_rr #(.WIDTH(8), .N_CH(3), .MODE(MUX_MODE_SEL)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(din[23:0]), .in_valid(vld[3][2:0]), .in_ready(rdy3),
      .sel(sel), .out_data(od3), .out_valid(ov3), .out_ready(ordy[3]), .out_ch(och3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference grant: -1 means no channel is granted.
   function automatic int model_gnt(input int n, input int mode, input logic [3:0] v,
                                    input int s, input int ptr);
      int c;
      if (mode == MUX_MODE_SEL) return (s < n && v[s[1:0]]) ? s : -1;
      for (int k = 0; k < n; k++) begin
         c = (ptr + k) % n;
         if (v[c[1:0]]) return c;
      end
      return -1;
   endfunction

   task automatic mon(input int id, input int n, input int mode, input logic [3:0] v,
                      input logic [3:0] r, input logic o_rdy, input logic o_v,
                      input logic [7:0] o_d, input logic [1:0] o_c);
      int g, exp_r, fi;
      g     = model_gnt(n, mode, v, int'(sel), m_ptr[id]);
      exp_r = 0;
      if (!rst && (!m_valid[id] || o_rdy) && g >= 0) exp_r = 1 << g;
      chk($sformatf("dut%0d_in_ready", id), int'(r), exp_r);
      chk($sformatf("dut%0d_out_valid", id), int'(o_v), int'(m_valid[id]));
      fi = -1;
      for (int k = 0; k < sbq.size(); k++)
         if (sbq[k].id == id) begin fi = k; break; end
      if (m_valid[id]) begin
         if (fi < 0) chk($sformatf("dut%0d_sb_empty", id), 0, 1);
         else begin
            chk($sformatf("dut%0d_out_data", id), int'(o_d), sbq[fi].data);
            chk($sformatf("dut%0d_out_ch", id), int'(o_c), sbq[fi].ch);
         end
      end
      // Advance the model to the state after the coming rising edge.
      if (rst) begin
         m_valid[id] = 0;
         m_ptr[id]   = 0;
         for (int k = sbq.size()-1; k >= 0; k--) if (sbq[k].id == id) sbq.delete(k);
      end else begin
         if (m_valid[id] && o_rdy) begin
            if (fi >= 0) sbq.delete(fi);
            m_valid[id] = 0;
         end
         if (exp_r != 0) begin
            sbq.push_back('{id, g, int'(din[g*8 +: 8])});
            m_valid[id] = 1;
            if (mode == MUX_MODE_RR) m_ptr[id] = (g == n-1) ? 0 : g + 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, 4, MUX_MODE_SEL, vld[0], rdy0, ordy[0], ov0, od0, och0);
         mon(1, 4, MUX_MODE_RR,  vld[1], rdy1, ordy[1], ov1, od1, och1);
         mon(2, 3, MUX_MODE_RR,  vld[2], {1'b0, rdy2}, ordy[2], ov2, od2, och2);
         mon(3, 3, MUX_MODE_SEL, vld[3], {1'b0, rdy3}, ordy[3], ov3, od3, och3);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      din = 32'h44A5_2211;
      sel = 2'd2;
      for (int i = 0; i < 4; i++) begin
         vld[i]  = 4'hF;
         ordy[i] = 1'b1;
         m_valid[i] = 0;
         m_ptr[i]   = 0;
      end

      // Reset with every channel valid: registers cleared, no ready.
      cyc(1);
      mon_en = 1;
      @(negedge clk);
      chk("rst_od0", int'(od0), 0);  chk("rst_och0", int'(och0), 0);
      chk("rst_od1", int'(od1), 0);  chk("rst_och1", int'(och1), 0);
      chk("rst_od2", int'(od2), 0);  chk("rst_och2", int'(och2), 0);
      chk("rst_od3", int'(od3), 0);  chk("rst_och3", int'(och3), 0);
      cyc(1);
      rst = 1'b0;

      // Select mode on ch2 (0xA5), round-robin sweeps, 3-channel 0/2 alternation.
      vld[0] = 4'b0100;
      vld[2] = 4'b0101;
      vld[3] = 4'b0111;
      cyc(6);
      sel = 2'd1;
      cyc(2);
      sel = 2'd3;
      cyc(3);

      // Backpressure on the 4-channel arbiter with changing input data.
      ordy[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = $urandom();
         cyc(1);
      end
      ordy[1] = 1'b1;
      cyc(2);

      // Random traffic on all instances.
      for (int i = 0; i < 300; i++) begin
         din = $urandom();
         sel = 2'($urandom());
         for (int j = 0; j < 4; j++) begin
            vld[j]  = 4'($urandom());
            ordy[j] = ($urandom_range(0, 3) != 0);
         end
         cyc(1);
      end

      // Reset while a word is stalled; pointer must return to 0.
      for (int j = 0; j < 4; j++) ordy[j] = 1'b1;
      vld[1] = 4'b0100;
      cyc(1);
      ordy[1] = 1'b0;
      vld[1]  = 4'hF;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", int'(ov1), 0);
      @(posedge clk);
      #1;
      vld[1]  = 4'b1010;
      ordy[1] = 1'b1;
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
